// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, functs, FSM states,
// ALU operations, plus small decode/ALU helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  function automatic logic is_legal(input logic [31:0] ins);
    logic ok;
    ok = 1'b0;
    case (ins[31:26])
      OP_RTYPE: begin
        case (ins[5:0])
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
          default:                               ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic alu_op_t alu_ctrl(input logic [31:0] ins);
    alu_op_t op;
    op = ALU_ADD;
    if (ins[31:26] == OP_RTYPE) begin
      case (ins[5:0])
        FN_SUB:  op = ALU_SUB;
        FN_AND:  op = ALU_AND;
        FN_OR:   op = ALU_OR;
        FN_SLT:  op = ALU_SLT;
        default: op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'b0, ($signed(a) < $signed(b))};
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port; register 0 reads as zero and ignores writes.
module mips_regfile (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o
);

  logic [31:0] regs_q [32];

  // NOTE: the storage array has no reset so it maps onto plain RAM/flops;
  // software must write a register before relying on its value.
  // NOTE: sequential state uses <= so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mips_multiciclo.sv
// Multicycle MIPS core with its own control FSM, one shared memory port with
// a req/ready handshake, configurable PC granularity, retire and trap status.
module mips_multiciclo
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       PC_SHIFT = 0,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_done,
  output logic              trap
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1) << PC_SHIFT;
  localparam logic [ADDR_W-1:0] J_MASK  = (ADDR_W'(1) << (26 + PC_SHIFT)) - ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]       alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              instr_done_q, instr_done_d, trap_q, trap_d;

  logic [5:0]        opcode;
  logic signed [31:0] imm_sext;
  logic [31:0]       alu_b, alu_res, rf_a, rf_b, rf_wdata;
  logic [4:0]        rf_waddr;
  logic              rf_we, handshake;
  logic [ADDR_W-1:0] br_target, j_target;

  assign opcode    = ir_q[31:26];
  assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign handshake = mem_req_q && mem_ready;
  assign alu_b     = (opcode == OP_RTYPE) ? b_q : imm_sext;
  assign alu_res   = alu(alu_ctrl(ir_q), a_q, alu_b);
  assign br_target = pc_q + (ADDR_W'(imm_sext) << PC_SHIFT);
  assign j_target  = (pc_q & ~J_MASK) | (ADDR_W'(ir_q[25:0]) << PC_SHIFT);
  assign rf_waddr  = (opcode == OP_RTYPE) ? ir_q[15:11] : ir_q[20:16];
  assign rf_wdata  = (opcode == OP_LW) ? mdr_q : alu_out_q;

  mips_regfile u_regfile (
    .clk       (clk),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (ir_q[25:21]),
    .rdata_a_o (rf_a),
    .raddr_b_i (ir_q[20:16]),
    .rdata_b_o (rf_b)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_out_q    <= '0;
      mdr_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      instr_done_q <= 1'b0;
      trap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      alu_out_q    <= alu_out_d;
      mdr_q        <= mdr_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      instr_done_q <= instr_done_d;
      trap_q       <= trap_d;
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (handshake) state_d = DECODE;
      DECODE:  state_d = is_legal(ir_q) ? EXEC : TRAP;
      EXEC: begin
        case (opcode)
          OP_BEQ, OP_J: state_d = FETCH;
          OP_LW, OP_SW: state_d = MEM;
          default:      state_d = WB;
        endcase
      end
      MEM:     if (handshake) state_d = (opcode == OP_SW) ? FETCH : WB;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    alu_out_d    = alu_out_q;
    mdr_d        = mdr_q;
    trap_d       = trap_q | (state_d == TRAP);
    rf_we        = 1'b0;
    case (state_q)
      FETCH: begin
        if (handshake) begin
          ir_d = mem_rdata;
          pc_d = pc_q + PC_STEP;
        end
      end
      DECODE: begin
        a_d = rf_a;
        b_d = rf_b;
      end
      EXEC: begin
        alu_out_d = alu_res;
        if (opcode == OP_BEQ && a_q == b_q) pc_d = br_target;
        if (opcode == OP_J)                 pc_d = j_target;
      end
      MEM:     if (handshake && opcode == OP_LW) mdr_d = mem_rdata;
      WB:      rf_we = rst;
      default: ;
    endcase

    // Retirement is known one cycle ahead for WB and for EXEC-retiring branches/jumps.
    instr_done_d = (state_d == WB) ||
                   (state_q == DECODE && state_d == EXEC && (opcode == OP_BEQ || opcode == OP_J));

    // Memory outputs are registered from the next state so they hold while waiting.
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == FETCH) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = pc_d;
    end else if (state_d == MEM) begin
      mem_req_d   = 1'b1;
      mem_we_d    = (opcode == OP_SW);
      mem_addr_d  = ADDR_W'(alu_out_d);
      mem_wdata_d = b_q;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign pc         = pc_q;
  assign trap       = trap_q;
  // A store retires in its handshake cycle, whose timing only the memory knows.
  assign instr_done = instr_done_q || (state_q == MEM && opcode == OP_SW && handshake);

endmodule

// File: tb/tb_mips_multiciclo.sv
// Directed bench for mips_multiciclo: small programs in a word-addressed
// memory model, store log, configurable store wait states and a load stall.
module tb_mips_multiciclo;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, instr_done, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  logic [31:0] mem [64];
  int          store_wait;
  logic        stall_lw;
  int          wait_cnt = 0;
  int          st_cnt = 0;
  logic [31:0] st_addr_log [32];
  logic [31:0] st_data_log [32];
  int          errors = 0;
  int          checks = 0;
  int          base;

  always #5 clk = ~clk;

  mips_multiciclo #(.ADDR_W(32), .PC_SHIFT(0), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pc         (pc),
    .instr_done (instr_done),
    .trap       (trap)
  );

  assign mem_rdata = mem[mem_addr[5:0]];
  assign mem_ready = !(stall_lw && !mem_we && mem_addr == 32'd8) &&
                     (!mem_we || wait_cnt >= store_wait);

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
    if (mem_req && mem_ready && mem_we && st_cnt < 32) begin
      st_addr_log[st_cnt] <= mem_addr;
      st_data_log[st_cnt] <= mem_wdata;
      st_cnt              <= st_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_prog(input int which);
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    case (which)
      0: begin
        mem[0] = 32'h20010005;  // addi $1,$0,5
        mem[1] = 32'h00211020;  // add  $2,$1,$1
        mem[2] = 32'hAC020003;  // sw   $2,3($0)
      end
      1: begin
        mem[0] = 32'h20010005;  // addi $1,$0,5
        mem[1] = 32'h20030009;  // addi $3,$0,9
        mem[2] = 32'h08000004;  // j    4
        mem[3] = 32'h20050002;  // addi $5,$0,2
        mem[4] = 32'h1021FFFE;  // beq  $1,$1,-2
        mem[5] = 32'hFC000000;  // illegal
      end
      2: begin
        mem[0]  = 32'h2001FFFD; // addi $1,$0,-3
        mem[1]  = 32'h20020005; // addi $2,$0,5
        mem[2]  = 32'h0022182A; // slt  $3,$1,$2
        mem[3]  = 32'h00412022; // sub  $4,$2,$1
        mem[4]  = 32'h00222824; // and  $5,$1,$2
        mem[5]  = 32'h00223025; // or   $6,$1,$2
        mem[6]  = 32'hAC030020; // sw   $3,32($0)
        mem[7]  = 32'hAC040021; // sw   $4,33($0)
        mem[8]  = 32'hAC050022; // sw   $5,34($0)
        mem[9]  = 32'hAC060023; // sw   $6,35($0)
        mem[10] = 32'h8C070028; // lw   $7,40($0)
        mem[11] = 32'hAC070024; // sw   $7,36($0)
        mem[12] = 32'h0041402A; // slt  $8,$2,$1
        mem[13] = 32'hAC080025; // sw   $8,37($0)
        mem[14] = 32'hFC000000; // illegal
        mem[40] = 32'hCAFEF00D;
      end
      default: begin
        mem[0] = 32'h20060011;  // addi $6,$0,0x11
        mem[1] = 32'h8C060008;  // lw   $6,8($0)
        mem[8] = 32'h00000055;
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; store_wait = 0; stall_lw = 1'b0;

    // Reset and two ALU instructions, then a store with three wait states.
    load_prog(0);
    cyc(2);
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'h0);
    check("rst_trap", {31'b0, trap}, 32'h0);
    check("rst_done", {31'b0, instr_done}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    rst = 1'b1; store_wait = 3;
    cyc(1);
    check("c1_req", {31'b0, mem_req}, 32'h1);
    check("c1_addr", mem_addr, 32'h0);
    check("c1_we", {31'b0, mem_we}, 32'h0);
    for (int c = 2; c <= 8; c++) begin
      cyc(1);
      check($sformatf("alu_done_c%0d", c), {31'b0, instr_done}, {31'b0, (c == 4 || c == 8)});
      if (c == 2) check("c2_req_low", {31'b0, mem_req}, 32'h0);
    end
    check("alu_pc", pc, 32'h2);
    cyc(1);
    check("sw_fetch_addr", mem_addr, 32'h2);
    base = st_cnt;
    cyc(2);
    for (int c = 12; c <= 15; c++) begin
      cyc(1);
      check($sformatf("sw_req_c%0d", c), {31'b0, mem_req}, 32'h1);
      check($sformatf("sw_we_c%0d", c), {31'b0, mem_we}, 32'h1);
      check($sformatf("sw_addr_c%0d", c), mem_addr, 32'h3);
      check($sformatf("sw_wdata_c%0d", c), mem_wdata, 32'd10);
      check($sformatf("sw_done_c%0d", c), {31'b0, instr_done}, {31'b0, (c == 15)});
    end
    cyc(1);
    check("sw_count", st_cnt - base, 32'h1);
    check("sw_log_addr", st_addr_log[base], 32'h3);
    check("sw_log_data", st_data_log[base], 32'd10);
    check("sw_after_done", {31'b0, instr_done}, 32'h0);
    check("sw_next_fetch", mem_addr, 32'h3);

    // Jump then taken branch.
    rst = 1'b0; store_wait = 0;
    load_prog(1);
    cyc(2);
    rst = 1'b1;
    cyc(9);
    check("j_fetch_addr", mem_addr, 32'h2);
    cyc(1);
    check("j_done_c10", {31'b0, instr_done}, 32'h0);
    cyc(1);
    check("j_done_c11", {31'b0, instr_done}, 32'h1);
    cyc(1);
    check("j_target", mem_addr, 32'h4);
    check("j_target_req", {31'b0, mem_req}, 32'h1);
    cyc(2);
    check("beq_t_done", {31'b0, instr_done}, 32'h1);
    cyc(1);
    check("beq_t_target", mem_addr, 32'h3);
    check("beq_t_pc", pc, 32'h3);

    // Not-taken branch falls into an illegal opcode.
    rst = 1'b0;
    mem[4] = 32'h1023FFFE;  // beq $1,$3,-2
    cyc(1);
    rst = 1'b1;
    cyc(14);
    check("beq_nt_done", {31'b0, instr_done}, 32'h1);
    cyc(1);
    check("beq_nt_addr", mem_addr, 32'h5);
    cyc(1);
    check("trap_decode", {31'b0, trap}, 32'h0);
    cyc(1);
    check("trap_set", {31'b0, trap}, 32'h1);
    check("trap_req", {31'b0, mem_req}, 32'h0);
    for (int c = 18; c <= 20; c++) begin
      cyc(1);
      check($sformatf("trap_hold_c%0d", c), {trap, mem_req, instr_done}, 32'h4);
    end
    check("trap_pc", pc, 32'h6);
    rst = 1'b0;
    cyc(1);
    check("trap_clr", {31'b0, trap}, 32'h0);
    check("trap_clr_pc", pc, 32'h0);

    // Full ALU set, load, and signed compare, stored to memory.
    load_prog(2);
    base = st_cnt;
    rst = 1'b1;
    for (int n = 0; n < 400 && trap !== 1'b1; n++) @(negedge clk);
    check("alu_trap", {31'b0, trap}, 32'h1);
    check("alu_trap_pc", pc, 32'd15);
    check("alu_store_cnt", st_cnt - base, 32'd6);
    check("slt_true_addr", st_addr_log[base], 32'd32);
    check("slt_true", st_data_log[base], 32'h1);
    check("sub", st_data_log[base+1], 32'h8);
    check("and", st_data_log[base+2], 32'h5);
    check("or", st_data_log[base+3], 32'hFFFFFFFD);
    check("lw_data", st_data_log[base+4], 32'hCAFEF00D);
    check("lw_store_addr", st_addr_log[base+4], 32'd36);
    check("slt_false", st_data_log[base+5], 32'h0);

    // Reset while a load waits: request dropped, destination untouched.
    rst = 1'b0;
    load_prog(3);
    stall_lw = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(8);
    check("lw_mem_req", {31'b0, mem_req}, 32'h1);
    check("lw_mem_addr", mem_addr, 32'h8);
    check("lw_mem_we", {31'b0, mem_we}, 32'h0);
    cyc(2);
    check("lw_wait_addr", mem_addr, 32'h8);
    check("lw_wait_req", {31'b0, mem_req}, 32'h1);
    rst = 1'b0;
    cyc(1);
    check("abort_req", {31'b0, mem_req}, 32'h0);
    check("abort_pc", pc, 32'h0);
    check("abort_done", {31'b0, instr_done}, 32'h0);
    mem[0] = 32'hAC060009;  // sw $6,9($0)
    stall_lw = 1'b0;
    base = st_cnt;
    rst = 1'b1;
    cyc(4);
    check("keep_we", {31'b0, mem_we}, 32'h1);
    check("keep_addr", mem_addr, 32'h9);
    check("keep_wdata", mem_wdata, 32'h11);
    check("keep_done", {31'b0, instr_done}, 32'h1);
    cyc(1);
    check("keep_log", st_data_log[base], 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multiciclo.md
# mips_multiciclo

Parametrised multicycle successor to the single-cycle MIPS datapath. It has its own control FSM instead of externally driven control lines, one shared instruction/data memory port with a req/ready handshake that tolerates wait states, and a configurable PC addressing granularity. It sits between the system memory and the testbench/SoC top, and exposes retire and trap status for verification.

## Interface
Parameters:
- ADDR_W, 32, memory address and PC width (≥ 26+PC_SHIFT+1).
- PC_SHIFT, 0, log2 of PC increment: 0 = word-addressed memory (PC+1), 2 = byte-addressed (PC+4).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write (sw), 0 = read (fetch/lw).
- mem_addr  out  ADDR_W  transaction address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the mem_ready cycle.
- mem_ready  in  1  transaction completes in the cycle mem_req && mem_ready.
- pc  out  ADDR_W  current PC register.
- instr_done  out  1  one-cycle pulse in the final cycle of each retired instruction.
- trap  out  1  sticky illegal-instruction flag.

## Operation
- ISA subset: R-type (op 0x00; funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- Any other opcode or funct sends the core to TRAP.
- Arithmetic is 32-bit two's complement and wraps; no overflow exception. slt is signed and writes 1 or 0.
- Immediates are sign-extended to 32 bits. Effective address = rs + sext(imm), truncated to ADDR_W.
- Register $0 always reads 0; writes to it are discarded.
- R-type writes rd; addi and lw write rt.
- Branch target = (PC+step) + (sext(imm) << PC_SHIFT), where step = 1<<PC_SHIFT.
- Jump target = {PC_plus[ADDR_W-1:26+PC_SHIFT], ins[25:0], PC_SHIFT zeros}.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On handshake, latch IR and set pc ← pc+step, then go to DECODE.
  - DECODE: read rs/rt into A/B, decode. Illegal → TRAP, else → EXEC.
  - EXEC: ALU computes. beq: if A==B, pc ← target; retire; → FETCH. j: pc ← jump target; retire; → FETCH. lw/sw → MEM. R/addi → WB.
  - MEM: mem_req=1, mem_addr=ALUout, mem_we=(sw), mem_wdata=B. On handshake: sw retires → FETCH; lw latches MDR → WB.
  - WB: write the register file; retire; → FETCH.
  - TRAP: mem_req=0, trap=1. Stays until reset.
- Reset (rst=0 at an edge): pc=RESET_PC, state=FETCH, IR/A/B/ALUout/MDR=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr_done=0, trap=0.
- Register-file contents are not reset.

## Timing
- Handshake rules:
  - Once mem_req is asserted, mem_we, mem_addr and mem_wdata stay stable until mem_ready is sampled high.
  - mem_req deasserts or changes target only after completion.
  - Zero-wait memory may tie mem_ready=1.
- Latency with zero wait states: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3. Each wait cycle on a memory access adds exactly 1.
- instr_done is registered: high for exactly one cycle, in the final state cycle of the instruction.
- mem_req is a registered output. The first fetch request is visible in the first cycle after rst returns high.
- Reset mid-transaction: the pending request is abandoned. mem_req is 0 in the cycle after the reset edge; no register write or pc update from the aborted instruction.
- Register-file write in WB takes effect at that clock edge; the next instruction's DECODE sees it (no bypass needed).

## Structure
- Package mips_pkg holds:
  - opcode and funct localparams;
  - state enum (FETCH…TRAP);
  - ALU control encoding (ADD, SUB, AND, OR, SLT).
- Sub-module mips_regfile: 32×32, 2 asynchronous read ports, 1 synchronous write port; $0 forced to zero. It is instantiated once.
- ALU, sign extension and the FSM stay inline in mips_multiciclo.

## Test plan
All scenarios use PC_SHIFT=0 and RESET_PC=0.
- Reset: hold rst=0 for 2 cycles → pc=0, mem_req=0, trap=0, instr_done=0. First cycle after release: mem_req=1, mem_addr=0, mem_we=0.
- ALU ops, zero-wait memory: program 0x20010005 (addi $1,$0,5) then 0x00211020 (add $2,$1,$1) → $2=10. instr_done pulses in cycles 4 and 8 after reset release; pc=2.
- Store with wait states: 0xAC020003 (sw $2,3($0)), mem_ready delayed 3 cycles → mem_we=1, mem_addr=3, mem_wdata=10, all held stable 4 cycles. Instruction takes 7 cycles.
- Branch: at pc=4, 0x1021FFFE (beq $1,$1,-2) → next fetch address 3. With $1≠$3 (0x1023FFFE) → next fetch address 5. Both take 3 cycles.
- Illegal opcode: 0xFC000000 → trap=1 after DECODE, mem_req stays 0, no instr_done. Then rst=0 → trap=0, pc=0.
- Reset during lw wait: lw issues MEM with mem_ready=0, then rst=0 → mem_req=0 next cycle, pc=0, destination register unchanged.
